pong_game_ctrl: RTL



---
 rtl/pong_game_ctrl.sv | 115 +++++++++++
 1 files changed

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: IDLE -> SERVE -> PLAY -> OVER, with BCD score, lives and serve timing.
// Define PONG_AUTO_SERVE_EN to serve automatically once the serve delay expires.
module pong_game_ctrl #(
  parameter int LIVES              = 3,
  parameter int SERVE_DELAY_FRAMES = 60,
  parameter int TIMER_WIDTH        = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       vsync,
  input  logic       btn_start,
  input  logic       ball_hit,
  input  logic       ball_miss,
  output logic       graph_still,
  output logic       ball_reload,
  output logic [7:0] score_bcd,
  output logic [1:0] lives_left,
  output logic       game_over,
  output logic [1:0] state
);
  typedef enum logic [1:0] {IDLE = 2'b00, SERVE = 2'b01, PLAY = 2'b10, OVER = 2'b11} state_t;

  localparam logic [TIMER_WIDTH-1:0] DELAY      = TIMER_WIDTH'(SERVE_DELAY_FRAMES);
  localparam logic [1:0]             LIVES_INIT = 2'(LIVES);

  state_t                 st, st_n;
  logic                   s1, s2, s3, vsync_q;
  logic [TIMER_WIDTH-1:0] timer, timer_n;
  logic [7:0]             score_n;
  logic [1:0]             lives_n;
  logic                   reload_n, start_game;
  logic                   start_press, frame_tick, expired, serve_go;

  function automatic logic [7:0] bcd_inc(input logic [7:0] s);
    if (s == 8'h99)        return s;
    if (s[3:0] == 4'd9)    return {s[7:4] + 4'd1, 4'd0};
    return {s[7:4], s[3:0] + 4'd1};
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0; s2 <= 1'b0; s3 <= 1'b0; vsync_q <= 1'b0;
    end else begin
      s1 <= btn_start; s2 <= s1; s3 <= s2; vsync_q <= vsync;
    end
  end

  assign start_press = s2 & ~s3;
  assign frame_tick  = vsync & ~vsync_q;
  assign expired     = (timer == DELAY);
`ifdef PONG_AUTO_SERVE_EN
  assign serve_go    = expired;
`else
  assign serve_go    = start_press & expired;
`endif

  always_comb begin
    st_n       = st;
    timer_n    = timer;
    score_n    = score_bcd;
    lives_n    = lives_left;
    reload_n   = 1'b0;
    start_game = 1'b0;
    case (st)
      IDLE, OVER: start_game = start_press;
      SERVE: begin
        // ball_reload marks the entry cycle; a tick there does not count
        if (frame_tick && !ball_reload && !expired) timer_n = timer + 1'b1;
        if (serve_go) st_n = PLAY;
      end
      PLAY: begin
        if (ball_hit) score_n = bcd_inc(score_bcd);
        if (ball_miss) begin
          if (lives_left > 2'd1) begin
            lives_n  = lives_left - 2'd1;
            reload_n = 1'b1;
            timer_n  = '0;
            st_n     = SERVE;
          end else begin
            lives_n = 2'd0;
            st_n    = OVER;
          end
        end
      end
      default: st_n = IDLE;
    endcase
    if (start_game) begin
      score_n  = 8'h00;
      lives_n  = LIVES_INIT;
      reload_n = 1'b1;
      timer_n  = '0;
      st_n     = SERVE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st          <= IDLE;
      timer       <= '0;
      score_bcd   <= 8'h00;
      lives_left  <= LIVES_INIT;
      ball_reload <= 1'b0;
    end else begin
      st          <= st_n;
      timer       <= timer_n;
      score_bcd   <= score_n;
      lives_left  <= lives_n;
      ball_reload <= reload_n;
    end
  end

  assign state       = st;
  assign graph_still = (st != PLAY);
  assign game_over   = (st == OVER);
endmodule
